// File: rtl/ei_mac10_job_seq.sv
// ei_mac10_job_seq: job sequencer for the 10-lane 8x8 pipelined MAC.
// Clears the MAC, streams chunks, counts returns, presents the final acc.
module ei_mac10_job_seq #(
    parameter int LAT     = 3,
    parameter int NCH_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [NCH_W-1:0] cmd_nchunks,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [79:0]      in_a,
    input  logic [79:0]      in_b,
    output logic             mac_en,
    output logic             mac_valid_in,
    output logic             mac_clr_acc,
    output logic [79:0]      mac_a_vec,
    output logic [79:0]      mac_b_vec,
    input  logic [31:0]      mac_acc_out,
    input  logic             mac_valid_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_err,
    output logic             busy,
    output logic [15:0]      jobs_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    // Abort decided here so res_valid lands TIMEOUT cycles after the last return
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

    state_t           state;
    state_t           state_nx;
    logic [NCH_W-1:0] nchunks;
    logic [NCH_W-1:0] issued;
    logic [NCH_W-1:0] returned;
    logic [NCH_W-1:0] returned_inc;
    logic [WD_W-1:0]  wd;
    logic             in_hs;
    logic             res_hs;
    logic             last_issue;
    logic             res_load;
    logic             res_zero;
    logic             res_err_nx;

    assign mac_en       = ~rst;
    assign cmd_ready    = ~rst & (state == S_IDLE);
    assign in_ready     = ~rst & (state == S_STREAM) & (issued != nchunks);
    assign mac_clr_acc  = ~rst & (state == S_CLEAR);
    assign res_valid    = ~rst & (state == S_RESULT);
    assign busy         = (state != S_IDLE);
    assign in_hs        = in_valid & in_ready;
    assign res_hs       = res_valid & res_ready;
    assign last_issue   = (issued + NCH_W'(1)) == nchunks;
    assign returned_inc = returned + NCH_W'(mac_valid_out);

    always_comb begin
        state_nx   = state;
        res_load   = 1'b0;
        res_zero   = 1'b0;
        res_err_nx = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                if (nchunks == '0) begin
                    state_nx = S_RESULT;
                    res_load = 1'b1;
                    res_zero = 1'b1;
                end else begin
                    state_nx = S_STREAM;
                end
            end
            S_STREAM: begin
                if (in_hs && last_issue) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (mac_valid_out && returned_inc == nchunks) begin
                    state_nx = S_RESULT;
                    res_load = 1'b1;
                end else if (!mac_valid_out && wd == WD_LAST) begin
                    state_nx   = S_RESULT;
                    res_load   = 1'b1;
                    res_err_nx = 1'b1;
                end
            end
            S_RESULT: begin
                if (res_hs) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            nchunks      <= '0;
            issued       <= '0;
            returned     <= '0;
            wd           <= '0;
            mac_valid_in <= 1'b0;
            mac_a_vec    <= '0;
            mac_b_vec    <= '0;
            res_data     <= '0;
            res_err      <= 1'b0;
            jobs_done    <= '0;
        end else begin
            state        <= state_nx;
            mac_valid_in <= in_hs;
            if (in_hs) begin
                mac_a_vec <= in_a;
                mac_b_vec <= in_b;
                issued    <= issued + NCH_W'(1);
            end
            if (cmd_valid && cmd_ready) begin
                nchunks  <= cmd_nchunks;
                issued   <= '0;
                returned <= '0;
            end
            if ((state == S_STREAM || state == S_DRAIN) && mac_valid_out)
                returned <= returned_inc;
            if (state != S_DRAIN || mac_valid_out)
                wd <= '0;
            else
                wd <= wd + WD_W'(1);
            if (res_load) begin
                res_data <= res_zero ? 32'd0 : mac_acc_out;
                res_err  <= res_err_nx;
            end
            if (res_hs) jobs_done <= jobs_done + 16'd1;
        end
    end

endmodule

// File: tb/tb_ei_mac10_job_seq.sv
// tb_ei_mac10_job_seq: table vectors, corner sequences and random jobs
// against a MAC stub and a sum-of-products reference model.
module tb_ei_mac10_job_seq;

    localparam int LAT     = 3;
    localparam int NCH_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int LIM     = 300;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [NCH_W-1:0] cmd_nchunks = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [79:0]      in_a = '0;
    logic [79:0]      in_b = '0;
    logic             mac_en;
    logic             mac_valid_in;
    logic             mac_clr_acc;
    logic [79:0]      mac_a_vec;
    logic [79:0]      mac_b_vec;
    logic [31:0]      mac_acc_out;
    logic             mac_valid_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;
    logic             res_err;
    logic             busy;
    logic [15:0]      jobs_done;

    ei_mac10_job_seq #(.LAT(LAT), .NCH_W(NCH_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_nchunks(cmd_nchunks),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .mac_en(mac_en), .mac_valid_in(mac_valid_in),
        .mac_clr_acc(mac_clr_acc),
        .mac_a_vec(mac_a_vec), .mac_b_vec(mac_b_vec),
        .mac_acc_out(mac_acc_out), .mac_valid_out(mac_valid_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err),
        .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // MAC stub: LAT-deep pipe, accumulator, optional dropped response
    logic [LAT-1:0] sv;
    logic [31:0]    sd [LAT];
    logic [31:0]    sacc;
    int             sn;
    int             drop_nth = 0;

    function automatic logic [31:0] dot(input logic [79:0] a, input logic [79:0] b);
        logic [31:0] s = 0;
        for (int i = 0; i < 10; i++)
            s += 32'(a[8*i +: 8]) * 32'(b[8*i +: 8]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst || mac_clr_acc) begin
            sv   <= '0;
            sacc <= '0;
            sn   <= 0;
        end else begin
            sv[0] <= mac_valid_in;
            sd[0] <= dot(mac_a_vec, mac_b_vec);
            for (int i = 1; i < LAT; i++) begin
                sv[i] <= sv[i-1];
                sd[i] <= sd[i-1];
            end
            if (sv[LAT-2]) begin
                sn <= sn + 1;
                if (sn + 1 == drop_nth) sv[LAT-1] <= 1'b0;
                else sacc <= sacc + sd[LAT-2];
            end
        end
    end
    assign mac_valid_out = sv[LAT-1];
    assign mac_acc_out   = sacc;

    int nvin = 0, nclr = 0, nboth = 0, last_vout = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (mac_valid_in) nvin++;
            if (mac_clr_acc) nclr++;
            if (mac_valid_in && mac_clr_acc) nboth++;
            if (mac_valid_out) last_vout = cyc;
        end
    end

    int n_pass = 0, n_total = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    logic [79:0] qa [16];
    logic [79:0] qb [16];
    logic [15:0] jd_exp = 0;

    task automatic wait_in(output bit ok);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < LIM) begin
            @(negedge clk);
            w++;
        end
        ok = in_ready;
    endtask

    task automatic run_job(input int n, input int gap, input int rdly,
                           input logic [31:0] exp, input bit exp_err,
                           input int exp_lat, input string nm);
        int  t0, tv, w, vin0, clr0;
        bit  ok, hold_ok;
        logic [31:0] d0;
        @(posedge clk); #1;
        cmd_valid   = 1'b1;
        cmd_nchunks = NCH_W'(n);
        res_ready   = (rdly == 0);
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < LIM) begin
            @(negedge clk);
            w++;
        end
        t0   = cyc;
        vin0 = nvin;
        clr0 = nclr;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_a     = qa[k];
            in_b     = qb[k];
            in_valid = 1'b1;
            wait_in(ok);
            if (!ok) begin
                chk({nm, " in_wait"}, 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (gap > 0 && k < n - 1) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
        w = 0;
        @(negedge clk);
        while (!res_valid && w < LIM) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " res_seen"}, res_valid, 1);
        tv = cyc;
        chk({nm, " data"}, res_data, exp);
        chk({nm, " err"}, res_err, exp_err);
        if (exp_lat >= 0) chk({nm, " lat"}, tv - t0, exp_lat);
        if (exp_err) chk({nm, " wd_lat"}, tv - last_vout, TIMEOUT);
        else if (n > 0) chk({nm, " vout_lat"}, tv - last_vout, 1);
        d0 = res_data;
        hold_ok = 1'b1;
        if (rdly > 0) begin
            repeat (rdly) begin
                @(negedge clk);
                if (!res_valid || res_data !== d0) hold_ok = 1'b0;
            end
            chk({nm, " hold"}, hold_ok, 1);
            res_ready = 1'b1;
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        jd_exp++;
        @(negedge clk);
        chk({nm, " jobs_done"}, jobs_done, jd_exp);
        chk({nm, " vin_cnt"}, nvin - vin0, n);
        chk({nm, " clr_cnt"}, nclr - clr0, 1);
    endtask

    typedef struct {
        int          n;
        int          first;
        int          gap;
        int          rdly;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [4];
    int   la [4][10];
    int   lb [4][10];
    logic [79:0] ca [4];
    logic [79:0] cb [4];

    initial begin
        bit ok, rv;
        int n, gap, rdly, x, y;
        logic [31:0] exp;

        la = '{'{3,10,5,1,2,4,8,3,9,2}, '{1,2,3,4,5,6,7,8,9,10},
               '{5,4,3,2,1,10,8,6,4,2}, '{9,8,7,6,5,4,3,2,1,0}};
        lb = '{'{4,2,5,7,9,6,1,3,0,2}, '{1,2,3,4,5,6,7,8,9,10},
               '{10,8,6,4,2,5,4,3,2,1}, '{1,2,3,4,5,6,7,8,9,10}};
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 10; i++) begin
                ca[c][8*i +: 8] = 8'(la[c][i]);
                cb[c][8*i +: 8] = 8'(lb[c][i]);
            end
        tbl[0] = '{1, 0, 0, 0, 32'd127, 7};
        tbl[1] = '{2, 1, 3, 0, 32'd605, -1};
        tbl[2] = '{4, 0, 0, 5, 32'd897, -1};
        tbl[3] = '{0, 0, 0, 0, 32'd0, 2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst cmd_ready", cmd_ready, 0);
        chk("rst mac_en", mac_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle cmd_ready", cmd_ready, 1);
        chk("idle mac_en", mac_en, 1);
        chk("idle busy", busy, 0);
        chk("idle in_ready", in_ready, 0);
        chk("idle res_valid", res_valid, 0);
        chk("idle jobs_done", jobs_done, 0);
        chk("idle outs", {mac_valid_in, mac_clr_acc, res_err, res_data}, 0);
        chk("idle a_vec", mac_a_vec, 0);

        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < tbl[v].n; k++) begin
                qa[k] = ca[tbl[v].first + k];
                qb[k] = cb[tbl[v].first + k];
            end
            run_job(tbl[v].n, tbl[v].gap, tbl[v].rdly, tbl[v].exp,
                    1'b0, tbl[v].lat, $sformatf("vec%0d", v));
        end

        // Lost second response must trip the watchdog
        qa[0] = ca[1]; qb[0] = cb[1];
        qa[1] = ca[2]; qb[1] = cb[2];
        drop_nth = 2;
        run_job(2, 0, 0, 32'd385, 1'b1, -1, "wdog");
        drop_nth = 0;
        run_job(2, 0, 0, 32'd605, 1'b0, -1, "after_wdog");

        // Reset in the middle of a 4-chunk job
        for (int k = 0; k < 4; k++) begin
            qa[k] = ca[k];
            qb[k] = cb[k];
        end
        @(posedge clk); #1;
        cmd_valid   = 1'b1;
        cmd_nchunks = 8'd4;
        @(negedge clk);
        chk("mid cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_a = qa[k];
            in_b = qb[k];
            in_valid = 1'b1;
            wait_in(ok);
            chk("mid in_hs", ok, 1);
            @(posedge clk); #1;
        end
        in_a = qa[2];
        in_b = qb[2];
        rst  = 1'b1;
        @(negedge clk);
        chk("mid rst in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        jd_exp = 0;
        @(negedge clk);
        chk("mid busy", busy, 0);
        chk("mid in_ready", in_ready, 0);
        chk("mid jobs_done", jobs_done, 0);
        rv = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid) rv = 1'b1;
        end
        chk("mid no_res", rv, 0);
        qa[0] = ca[0];
        qb[0] = cb[0];
        run_job(1, 0, 0, 32'd127, 1'b0, 7, "post_rst");

        for (int j = 0; j < 25; j++) begin
            n    = $urandom_range(0, 6);
            gap  = $urandom_range(0, 2);
            rdly = $urandom_range(0, 3);
            exp  = 0;
            for (int k = 0; k < n; k++)
                for (int i = 0; i < 10; i++) begin
                    x = $urandom_range(0, 255);
                    y = $urandom_range(0, 255);
                    qa[k][8*i +: 8] = 8'(x);
                    qb[k][8*i +: 8] = 8'(y);
                    exp += 32'(x * y);
                end
            run_job(n, gap, rdly, exp, 1'b0, n == 0 ? 2 : -1,
                    $sformatf("rnd%0d", j));
        end

        chk("clr_vin_overlap", nboth, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ei_mac10_job_seq.md
Name: ei_mac10_job_seq

Overview:
Job sequencer for the 10-lane 8x8 pipelined MAC (ei_mac10_8x8_pipe). It accepts a dot-product job command (number of 10-element chunks), clears the MAC accumulator, streams chunks from an upstream valid/ready source into the MAC, and counts returned MAC valids. It then presents the final 32-bit accumulator value as a single result with valid/ready handshake. A drain watchdog flags lost MAC responses.

Parameters:
LAT, 3, MAC pipeline latency; must match the instantiated MAC.
NCH_W, 8, width of chunk counters; a job holds at most 2^NCH_W-1 chunks.
TIMEOUT, 16, maximum cycles between MAC valids in DRAIN before error abort; must be > LAT+1.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous active-high reset.
cmd_valid  in  1  job command valid.
cmd_ready  out  1  high only in IDLE.
cmd_nchunks  in  NCH_W  number of chunks in the job; 0 is legal.
in_valid  in  1  chunk data valid.
in_ready  out  1  chunk accepted when in_valid & in_ready.
in_a  in  80  ten unsigned 8-bit operands, lane 0 in [7:0].
in_b  in  80  ten unsigned 8-bit operands, lane 0 in [7:0].
mac_en  out  1  MAC enable.
mac_valid_in  out  1  one-cycle chunk strobe to the MAC.
mac_clr_acc  out  1  accumulator clear strobe to the MAC.
mac_a_vec  out  80  registered copy of in_a.
mac_b_vec  out  80  registered copy of in_b.
mac_acc_out  in  32  MAC accumulator.
mac_valid_out  in  1  MAC result strobe, one per mac_valid_in after LAT cycles.
res_valid  out  1  result valid; held until res_ready.
res_ready  in  1  result consumer ready.
res_data  out  32  final accumulator value.
res_err  out  1  qualifies res_data: 1 means the watchdog expired.
busy  out  1  high in any state other than IDLE.
jobs_done  out  16  count of completed results; wraps at 65535 to 0.

Behaviour:
- Reset values: cmd_ready=0 during rst, then 1; in_ready=0, mac_valid_in=0, mac_clr_acc=0, mac_a_vec=0, mac_b_vec=0, res_valid=0, res_data=0, res_err=0, busy=0, jobs_done=0; state=IDLE.
- mac_en=1 whenever rst=0; mac_en=0 during rst.
- MAC drive: mac_valid_in, mac_a_vec and mac_b_vec are registered. A chunk handshake in cycle t yields mac_valid_in=1 in cycle t+1 with that chunk's data. mac_valid_in and mac_clr_acc are never high in the same cycle.
- States:
  - IDLE: cmd_ready=1. When cmd_valid=1, latch nchunks, clear issued/returned counters, go to CLEAR.
  - CLEAR: mac_clr_acc=1 for exactly one cycle. If nchunks=0, go to RESULT with res_data=0 and res_err=0. Otherwise go to STREAM.
  - STREAM: in_ready=1 while issued<nchunks. Each handshake increments issued. in_valid gaps are allowed; there is no timeout in STREAM. When issued reaches nchunks, in_ready drops the same cycle the last handshake completes, and the state goes to DRAIN.
  - DRAIN: wait for returned=nchunks. On the mac_valid_out that makes returned=nchunks, capture mac_acc_out into res_data, set res_err=0, and go to RESULT. res_valid rises the next cycle.
  - Watchdog in DRAIN: a counter is cleared on entry and on every mac_valid_out. If it reaches TIMEOUT, capture mac_acc_out, set res_err=1, and go to RESULT.
  - RESULT: res_valid=1 with res_data/res_err stable until res_ready=1. On handshake, jobs_done increments and the state goes to IDLE, with cmd_ready=1 the next cycle.
- Returned counting: mac_valid_out increments returned in both STREAM and DRAIN. mac_valid_out in IDLE, CLEAR or RESULT is ignored.
- Latency:
  - Back-to-back inputs with n chunks: cmd handshake at T, clr at T+1, first chunk handshake at T+2, last mac_valid_in at T+2+n.
  - Last mac_valid_out at T+2+n+LAT; res_valid at T+3+n+LAT.
  - With LAT=3 and n=1, res_valid is at T+7.
- Arithmetic: the controller does no arithmetic on data; res_data equals mac_acc_out exactly (32-bit, unsigned, no saturation).
- Reset mid-job: all state is discarded, outputs return to reset values the next cycle, and no result is produced. in_ready drops so no chunk is accepted in a reset cycle.
- cmd_valid outside IDLE is not accepted (cmd_ready=0). The command must be held by the source.

Test Plan:
- Job nchunks=1, chunk a={3,10,5,1,2,4,8,3,9,2}, b={4,2,5,7,9,6,1,3,0,2} (lane0 first), res_ready=1 -> one mac_clr_acc pulse, one mac_valid_in, res_data=127, res_err=0, res_valid at T+7, jobs_done=1.
- Job nchunks=2: chunk 1 a=b={1..10}; chunk 2 a={5,4,3,2,1,10,8,6,4,2}, b={10,8,6,4,2,5,4,3,2,1}; in_valid gap of 3 cycles between chunks -> res_data=605, exactly 2 mac_valid_in pulses.
- Job nchunks=4: the four chunks above plus a={9..0}, b={1..10}; res_ready low for 5 cycles -> res_data=897 held stable, res_valid stays high, jobs_done increments once on handshake.
- Job nchunks=0 -> mac_clr_acc pulse, no mac_valid_in, res_data=0, res_err=0 two cycles after cmd handshake.
- MAC stub suppresses the 2nd mac_valid_out of a 2-chunk job -> res_err=1 TIMEOUT cycles after the last mac_valid_out; the next job is then accepted normally.
- rst asserted after 2 of 4 chunks -> busy=0, in_ready=0 the next cycle, no res_valid; a following nchunks=1 job returns 127.
